// File: rtl/bidir_pkg.sv
// Shared types and helpers for the registered bidirectional transceiver.
//   bidir_state_e : FSM state encoding (IDLE, A2B, B2A, TA)
//   DIR_A2B/B2A   : encodings of the dir input
//   ta_cnt_w()    : width of the turnaround counter for a given TURNAROUND
package bidir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      A2B  = 2'd1,
      B2A  = 2'd2,
      TA   = 2'd3
   } bidir_state_e;

   localparam logic DIR_A2B = 1'b1;
   localparam logic DIR_B2A = 1'b0;

   function automatic int ta_cnt_w(input int turnaround);
      return $clog2(turnaround + 1);
   endfunction

endpackage

// File: rtl/bidir_ta_timer.sv
// Turnaround down-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (entry into the turnaround window)
//   load_val   : value loaded on load
//   done       : count is zero (last turnaround cycle)
//   count      : current count
module bidir_ta_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done  = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/bidir_xcvr_reg.sv
// Registered bidirectional transceiver between tri-state buses a and b.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : 1 = transfer, 0 = release to idle
//   dir        : 1 = a drives b (A2B), 0 = b drives a (B2A)
//   a, b       : WIDTH-bit tri-state buses, driven only in B2A / A2B
//   a_oe, b_oe : 1 while the block drives a / b
//   ta_busy    : 1 during the high-Z turnaround window
//   turn_count : saturating count of completed direction changes
module bidir_xcvr_reg
   import bidir_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int TURNAROUND = 2,
   parameter int COUNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               dir,
   inout  wire  [WIDTH-1:0]   a,
   inout  wire  [WIDTH-1:0]   b,
   output logic               a_oe,
   output logic               b_oe,
   output logic               ta_busy,
   output logic [COUNT_W-1:0] turn_count
);

   localparam int TA_W = ta_cnt_w(TURNAROUND);

   bidir_state_e       state_d, state_q;
   logic [WIDTH-1:0]   dq_d, dq_q;
   logic               last_dir_d, last_dir_q;
   logic [COUNT_W-1:0] turn_count_d, turn_count_q;
   logic               ta_load;
   logic               ta_done;
   logic [TA_W-1:0]    ta_cnt;
   logic               enter_drive;

   bidir_ta_timer #(
      .CNT_W (TA_W)
   ) u_ta_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ta_load),
      .load_val (TA_W'(TURNAROUND - 1)),
      .done     (ta_done),
      .count    (ta_cnt)
   );

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d      = state_q;
      dq_d         = en ? (dir ? a : b) : dq_q;
      last_dir_d   = last_dir_q;
      turn_count_d = turn_count_q;
      ta_load      = 1'b0;
      enter_drive  = 1'b0;

      case (state_q)
         IDLE: enter_drive = en;
         A2B: begin
            if (!en || dir != DIR_A2B) begin
               state_d = TA;
               ta_load = 1'b1;
            end
         end
         B2A: begin
            if (!en || dir != DIR_B2A) begin
               state_d = TA;
               ta_load = 1'b1;
            end
         end
         TA: begin
            // Only en/dir at the final turnaround edge choose the exit.
            if (ta_done) begin
               if (en) enter_drive = 1'b1;
               else    state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_drive) begin
         state_d = (dir == DIR_A2B) ? A2B : B2A;
         // Only a real reversal counts; re-entry in the same direction does not.
         if (dir != last_dir_q) begin
            last_dir_d = dir;
            if (turn_count_q != '1) turn_count_d = turn_count_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from pre-edge values; blocking here would create order races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the data register is reset too, so the first driven word after
         // reset is a known zero rather than whatever powered up.
         state_q      <= IDLE;
         dq_q         <= '0;
         last_dir_q   <= DIR_A2B;
         turn_count_q <= '0;
      end else begin
         state_q      <= state_d;
         dq_q         <= dq_d;
         last_dir_q   <= last_dir_d;
         turn_count_q <= turn_count_d;
      end
   end

   assign b_oe       = (state_q == A2B);
   assign a_oe       = (state_q == B2A);
   assign ta_busy    = (state_q == TA);
   assign turn_count = turn_count_q;

   assign b = b_oe ? dq_q : {WIDTH{1'bz}};
   assign a = a_oe ? dq_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_xcvr_reg.sv
module tb_bidir_xcvr_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, dir;
   logic [7:0] a_drv, b_drv;
   logic       a_drv_en, b_drv_en;
   wire  [7:0] a, b;
   logic       a_oe, b_oe, ta_busy;
   logic [7:0] turn_count;

   assign a = a_drv_en ? a_drv : 8'hzz;
   assign b = b_drv_en ? b_drv : 8'hzz;

   // Second instance with a 2-bit counter for the saturation case.
   logic       en2, dir2;
   wire  [7:0] a2, b2;
   logic       a2_oe, b2_oe, ta2_busy;
   logic [1:0] turn_count2;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   bidir_xcvr_reg #(.WIDTH(8), .TURNAROUND(2), .COUNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .a(a), .b(b),
      .a_oe(a_oe), .b_oe(b_oe), .ta_busy(ta_busy), .turn_count(turn_count)
   );

   bidir_xcvr_reg #(.WIDTH(8), .TURNAROUND(2), .COUNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en2), .dir(dir2), .a(a2), .b(b2),
      .a_oe(a2_oe), .b_oe(b2_oe), .ta_busy(ta2_busy), .turn_count(turn_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both output enables must never be high together, on either instance.
   always @(negedge clk) begin
      if (mon_en) begin
         check("oe_excl", 32'(a_oe & b_oe), 32'd0);
         check("oe_excl_sat", 32'(a2_oe & b2_oe), 32'd0);
      end
   end

   int exp_sat[5] = '{1, 2, 3, 3, 3};

   initial begin
      rst_n = 1'b0; en = 1'b0; dir = 1'b1;
      a_drv = '0; b_drv = '0; a_drv_en = 1'b0; b_drv_en = 1'b0;
      en2 = 1'b0; dir2 = 1'b1;

      // 1. Reset then A2B
      tick(); tick();
      mon_en = 1'b1;
      check("rst_a_oe", 32'(a_oe), 0);
      check("rst_b_oe", 32'(b_oe), 0);
      check("rst_ta_busy", 32'(ta_busy), 0);
      check("rst_turn_count", 32'(turn_count), 0);
      rst_n = 1'b1; en = 1'b1; dir = 1'b1; a_drv = 8'hA5; a_drv_en = 1'b1;
      tick();
      check("a2b_b_oe", 32'(b_oe), 1);
      check("a2b_b", 32'(b), 32'h A5);
      check("a2b_turn_count", 32'(turn_count), 0);

      // 2. Direction change
      a_drv = 8'h3C;
      tick();
      check("a2b_b_3c", 32'(b), 32'h3C);
      dir = 1'b0;
      tick();
      a_drv_en = 1'b0;
      check("dc_ta1_busy", 32'(ta_busy), 1);
      check("dc_ta1_oe", 32'({a_oe, b_oe}), 0);
      tick();
      b_drv = 8'h5A; b_drv_en = 1'b1;
      check("dc_ta2_busy", 32'(ta_busy), 1);
      check("dc_ta2_oe", 32'({a_oe, b_oe}), 0);
      tick();
      check("dc_b2a_a_oe", 32'(a_oe), 1);
      check("dc_b2a_ta_busy", 32'(ta_busy), 0);
      check("dc_b2a_a", 32'(a), 32'h5A);
      check("dc_turn_count", 32'(turn_count), 1);

      // 3. en glitch, then en held low
      en = 1'b0;
      tick();
      check("gl_ta1_busy", 32'(ta_busy), 1);
      en = 1'b1; dir = 1'b0;
      tick();
      check("gl_ta2_busy", 32'(ta_busy), 1);
      tick();
      check("gl_b2a_a_oe", 32'(a_oe), 1);
      check("gl_b2a_a", 32'(a), 32'h5A);
      check("gl_turn_count", 32'(turn_count), 1);
      en = 1'b0;
      tick();
      check("hold_ta1_busy", 32'(ta_busy), 1);
      tick();
      check("hold_ta2_busy", 32'(ta_busy), 1);
      tick();
      check("hold_idle_oe", 32'({a_oe, b_oe}), 0);
      check("hold_idle_ta_busy", 32'(ta_busy), 0);

      // 4. dir toggling during turnaround
      b_drv_en = 1'b0; a_drv = 8'hC3; a_drv_en = 1'b1;
      en = 1'b1; dir = 1'b1;
      tick();
      check("tg_a2b_b", 32'(b), 32'hC3);
      check("tg_a2b_count", 32'(turn_count), 2);
      dir = 1'b0;
      tick();
      a_drv_en = 1'b0; b_drv = 8'h96; b_drv_en = 1'b1;
      check("tg_ta1_busy", 32'(ta_busy), 1);
      dir = 1'b1;
      tick();
      check("tg_ta2_busy", 32'(ta_busy), 1);
      dir = 1'b0;
      tick();
      check("tg_b2a_a_oe", 32'(a_oe), 1);
      check("tg_b2a_a", 32'(a), 32'h96);
      check("tg_count", 32'(turn_count), 3);

      // 5. Reset mid-transfer in A2B driving 8'hFF
      dir = 1'b1;
      tick();
      b_drv_en = 1'b0; a_drv = 8'hFF; a_drv_en = 1'b1;
      tick();
      tick();
      check("mr_a2b_b", 32'(b), 32'hFF);
      check("mr_a2b_count", 32'(turn_count), 4);
      rst_n = 1'b0;
      tick();
      check("mr_oe", 32'({a_oe, b_oe}), 0);
      check("mr_ta_busy", 32'(ta_busy), 0);
      check("mr_turn_count", 32'(turn_count), 0);
      check("mr_dq", 32'(u_dut.dq_q), 0);
      rst_n = 1'b1; en = 1'b0; a_drv_en = 1'b0;
      tick();

      // 6. Saturation on the 2-bit counter instance
      en2 = 1'b1; dir2 = 1'b0;
      tick();
      check("sat_a_oe_0", 32'(a2_oe), 1);
      check("sat_count_0", 32'(turn_count2), 32'(exp_sat[0]));
      for (int k = 1; k < 5; k++) begin
         dir2 = ~dir2;
         tick(); tick(); tick();
         check("sat_oe", 32'({a2_oe, b2_oe}), dir2 ? 32'b01 : 32'b10);
         check("sat_count", 32'(turn_count2), 32'(exp_sat[k]));
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bidir_xcvr_reg.md
Name: bidir_xcvr_reg

Overview:
Registered, parametrised bidirectional bus transceiver between two tri-state buses, a and b, each WIDTH bits wide.
- Direction is selected by dir; en gates the whole block.
- Data is retimed through one register stage.
- Every release of a driving state passes through a programmable turnaround window with both sides high-Z, so a and b are never driven by both ends at once.
- Sits between a shared external bus pad ring and internal bus segments.

Parameters:
WIDTH, 8, data bits per bus.
TURNAROUND, 2, high-Z cycles inserted on every exit from a driving state (legal range 1..15).
COUNT_W, 8, width of the saturating direction-change counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
en  input  1  1 = transfer enabled; 0 = request release to idle.
dir  input  1  1 = a drives b (A2B), 0 = b drives a (B2A).
a  inout  WIDTH  bus A; driven by block only in B2A, else high-Z.
b  inout  WIDTH  bus B; driven by block only in A2B, else high-Z.
a_oe  output  1  1 while block drives a.
b_oe  output  1  1 while block drives b.
ta_busy  output  1  1 while in turnaround.
turn_count  output  COUNT_W  saturating count of completed direction changes.

Behaviour:
- Reset is synchronous: rst_n=0 at a rising edge applies it.
  - Reset values: state=IDLE, data register dq=0, ta_cnt=0, last_dir=1, turn_count=0.
  - Therefore a_oe=0, b_oe=0, ta_busy=0, and both buses are high-Z.
  - Reset mid-transfer or mid-turnaround releases both buses at that edge; no turnaround is inserted.
- States: IDLE, A2B, B2A, TA.
- Outputs are decoded from the state register only:
  - b_oe = (state==A2B), and b = b_oe ? dq : 'z.
  - a_oe = (state==B2A), and a = a_oe ? dq : 'z.
  - ta_busy = (state==TA).
- Data register:
  - When en=1 at an edge: dq <= dir ? a : b.
  - When en=0: dq holds.
  - Latency is exactly 1 cycle: the driven bus shows the source value sampled at the previous edge.
- IDLE:
  - en=1 -> A2B if dir=1, else B2A, at the next edge. No turnaround is needed because nothing was being driven.
  - en=0 -> stay in IDLE.
- A2B / B2A:
  - Stay while en=1 and dir matches the current state.
  - en=0, or dir differs -> TA, with ta_cnt <= TURNAROUND-1.
- TA:
  - If ta_cnt != 0: ta_cnt decrements.
  - If ta_cnt == 0: en=0 -> IDLE; en=1 -> A2B/B2A chosen by dir sampled at that edge.
  - Net effect: exactly TURNAROUND high-Z cycles.
  - dir and en may toggle freely during TA; only their values at the final TA edge matter.
- turn_count and last_dir:
  - On entry to A2B/B2A whose direction != last_dir: turn_count++ (saturates at 2^COUNT_W-1, no wrap), and last_dir updates.
  - Re-entry in the same direction does not count; this includes a brief en drop, which still pays full turnaround.
- Simultaneous en=0 and dir flip in a drive state -> TA (same as either alone).
- Undriven or X source bits pass through dq unchanged; the block does not resolve or filter them.
- Both a_oe and b_oe high in the same cycle is illegal; the bench asserts it never occurs.

Decomposition:
- Package bidir_pkg holds:
  - state enum {IDLE, A2B, B2A, TA};
  - constants DIR_A2B=1'b1, DIR_B2A=1'b0;
  - function ta_cnt_w(TURNAROUND) returning $clog2(TURNAROUND+1).
- One sub-module, bidir_ta_timer:
  - inputs: load, load value, clk, rst_n;
  - outputs: done (ta_cnt==0) and the count.
  - Used by the FSM for the TA window.
- The tri-state drivers stay in the top level.

Test Plan:
(WIDTH=8, TURNAROUND=2.)
1. Reset then A2B.
   - Stimulus: rst_n=0 for 2 cycles, then en=1, dir=1, bench drives a=8'hA5.
   - Required: a_oe=b_oe=0 and b=8'hzz during reset; b_oe=1 and b=8'hA5 on the first cycle after the IDLE->A2B edge; turn_count=0.
2. Direction change.
   - Stimulus: in A2B with a=8'h3C, set dir=0; bench releases a and drives b=8'h5A from the second TA cycle.
   - Required: exactly 2 cycles with a_oe=b_oe=0 and ta_busy=1; then a_oe=1, a=8'h5A; turn_count=1.
3. en glitch.
   - Stimulus: in B2A, en=0 for 1 cycle then en=1 with dir=0.
   - Required: 2 TA cycles, return to B2A, turn_count unchanged; with en held 0 instead, final state IDLE and both buses Z.
4. dir toggling during TA.
   - Stimulus: A2B->TA, dir=1 then 0 on the TA cycles, ending 0.
   - Required: enters B2A; no cycle with both a_oe and b_oe high.
5. Reset mid-transfer.
   - Stimulus: rst_n=0 for one edge while in A2B driving b=8'hFF.
   - Required: b=8'hzz the following cycle, ta_busy=0, turn_count=0, dq=0.
6. Saturation.
   - Stimulus: with COUNT_W=2, perform 5 direction changes.
   - Required: turn_count reads 1, 2, 3, 3, 3.
